// File: rtl/vg8020_dram_pkg.sv
`default_nettype none
// ==== vg8020_dram_pkg: shared state encoding and defaults for the VG8020 DRAM controller ====
// Rev 1.0
package vg8020_dram_pkg;

  localparam int ROW_W_DEF            = 8;
  localparam int PRECHARGE_CYCLES_DEF = 2;
  localparam int MUX_DELAY_DEF        = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RAS  = 3'd1,
    ST_MUX  = 3'd2,
    ST_CAS  = 3'd3,
    ST_REF  = 3'd4,
    ST_PRE  = 3'd5
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vg8020_dram_refcnt.sv
`default_nettype none
// ==== vg8020_dram_refcnt: wrapping refresh-row counter with increment enable ====
// Rev 1.0
module vg8020_dram_refcnt
  import vg8020_dram_pkg::*;
#(
  parameter int W = ROW_W_DEF
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/vg8020_dram_ctrl.sv
`default_nettype none
// ==== vg8020_dram_ctrl: Z80 slot-3 DRAM sequencer (RAS/CAS, RAS-only refresh, precharge waits) ====
// Rev 1.0 | define VG8020_DRAM_REFCNT_EN to take the refresh row from an internal counter
module vg8020_dram_ctrl
  import vg8020_dram_pkg::*;
#(
  parameter int ROW_W            = ROW_W_DEF,
  parameter int PRECHARGE_CYCLES = PRECHARGE_CYCLES_DEF,
  parameter int MUX_DELAY        = MUX_DELAY_DEF
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               nmreq,
  input  logic               nrd,
  input  logic               nwr,
  input  logic               nrfsh,
  input  logic               nsltsl,
  input  logic [2*ROW_W-1:0] addr,
  output logic [ROW_W-1:0]   ma,
  output logic               nras,
  output logic               ncas,
  output logic               nwe,
  output logic               nwait
);

  localparam int CNT_W = $clog2(max2(PRECHARGE_CYCLES, MUX_DELAY) + 1);
  localparam logic [CNT_W-1:0] MUX_LAST = CNT_W'(MUX_DELAY - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE_CYCLES - 1);

  state_e           state_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] ma_q;
  logic             nras_q;
  logic             ncas_q;
  logic             nwe_q;
  logic             nwait_q;

  logic             ref_req;
  logic             acc_req;
  logic             ref_inc;
  logic             wr_strobe_n;
  logic [ROW_W-1:0] ref_row;

  assign ref_req = armed_q & ~nmreq & ~nrfsh;
  assign acc_req = armed_q & ~nmreq & nrfsh & ~nsltsl;
  assign ref_inc = (state_q == ST_REF) && nmreq;
  // A concurrent read strobe keeps nwe high so a malformed bus cycle cannot write.
  assign wr_strobe_n = nwr | ~nrd;

`ifdef VG8020_DRAM_REFCNT_EN
  vg8020_dram_refcnt #(
    .W (ROW_W)
  ) u_refcnt (
    .clk    (clk),
    .nreset (nreset),
    .inc_i  (ref_inc),
    .cnt_o  (ref_row)
  );
`else
  assign ref_row = addr[ROW_W-1:0];
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      ma_q    <= '0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      nwe_q   <= 1'b1;
      nwait_q <= 1'b1;
    end else begin
      armed_q <= armed_q | nmreq;
      case (state_q)
        // The final precharge cycle doubles as the idle decision cycle, so a
        // queued request sees exactly PRECHARGE_CYCLES of nras high.
        ST_IDLE, ST_PRE: begin
          if (state_q == ST_PRE && cnt_q != PRE_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (ref_req || acc_req) nwait_q <= 1'b0;
          end else begin
            nwait_q <= 1'b1;
            ma_q    <= addr[ROW_W-1:0];
            cnt_q   <= '0;
            if (ref_req) begin
              state_q <= ST_REF;
              nras_q  <= 1'b0;
              ma_q    <= ref_row;
            end else if (acc_req) begin
              state_q <= ST_RAS;
              nras_q  <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_RAS: begin
          if (nmreq) begin
            nras_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end else if (cnt_q == MUX_LAST) begin
            ma_q    <= addr[2*ROW_W-1:ROW_W];
            state_q <= ST_MUX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_MUX: begin
          if (nmreq) begin
            nras_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end else begin
            ncas_q  <= 1'b0;
            nwe_q   <= wr_strobe_n;
            state_q <= ST_CAS;
          end
        end
        ST_CAS: begin
          if (nmreq) begin
            nras_q  <= 1'b1;
            ncas_q  <= 1'b1;
            nwe_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end else begin
            nwe_q <= wr_strobe_n;
          end
        end
        ST_REF: begin
          if (nmreq) begin
            nras_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end
        end
        default: begin
          nras_q  <= 1'b1;
          ncas_q  <= 1'b1;
          nwe_q   <= 1'b1;
          nwait_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ma    = ma_q;
  assign nras  = nras_q;
  assign ncas  = ncas_q;
  assign nwe   = nwe_q;
  assign nwait = nwait_q;

endmodule
`default_nettype wire
